// File: rtl/matmul_pkg.sv
// ============================================================================
// matmul_pkg : shared state encoding and address helper for the matmul engine
// Rev 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

    localparam int MM_N  = 8;
    localparam int LOG2N = $clog2(MM_N);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // N is a power of two, so row*N+col is a shift-or with no carries.
    function automatic logic [31:0] row_major_addr(input logic [31:0] row,
                                                   input logic [31:0] col,
                                                   input int          log2n);
        return (row << log2n) | col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_mac.sv
// ============================================================================
// matmul_mac : registered multiply-accumulate, products and sums wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module matmul_mac #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] product;

    assign product = a * b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (valid) begin
            acc <= acc + product;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_engine.sv
// ============================================================================
// matmul_engine : reads X,Y from BRAMs, computes Z = X*Y, writes Z row-major
// Rev 1.0
// ============================================================================
`default_nettype none

module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int N          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_rd_addr,
    input  logic [DATA_WIDTH-1:0] x_dout,
    output logic [ADDR_WIDTH-1:0] y_rd_addr,
    input  logic [DATA_WIDTH-1:0] y_dout,
    output logic [ADDR_WIDTH-1:0] z_wr_addr,
    output logic                  z_wr_en,
    output logic [DATA_WIDTH-1:0] z_din
);

    localparam int             LOGN = $clog2(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    state_t                  state;
    state_t                  state_next;
    logic [LOGN-1:0]         i;
    logic [LOGN-1:0]         j;
    logic [LOGN-1:0]         k;
    logic                    pipe_valid;
    logic                    start_ok;
    logic                    acc_clear;
    logic [DATA_WIDTH-1:0]   acc;
    logic [ADDR_WIDTH-1:0]   x_addr_hold;
    logic [ADDR_WIDTH-1:0]   y_addr_hold;
    logic [ADDR_WIDTH-1:0]   x_addr_mac;
    logic [ADDR_WIDTH-1:0]   y_addr_mac;
    logic [ADDR_WIDTH-1:0]   z_addr_cur;

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign acc_clear  = start_ok || (state == ST_WRITE);
    assign x_addr_mac = ADDR_WIDTH'(row_major_addr(32'(i), 32'(k), LOGN));
    assign y_addr_mac = ADDR_WIDTH'(row_major_addr(32'(k), 32'(j), LOGN));
    assign z_addr_cur = ADDR_WIDTH'(row_major_addr(32'(i), 32'(j), LOGN));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_MAC;
            ST_MAC:           if (k == LAST) state_next = ST_DRAIN;
            ST_DRAIN:         state_next = ST_WRITE;
            ST_WRITE:         state_next = (i == LAST && j == LAST) ? ST_DONE : ST_MAC;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Read addresses are live only in MAC; elsewhere they replay the held value.
    always_comb begin
        x_rd_addr = x_addr_hold;
        y_rd_addr = y_addr_hold;
        z_wr_addr = z_addr_cur;
        z_wr_en   = 1'b0;
        z_din     = '0;
        case (state)
            ST_MAC: begin
                x_rd_addr = x_addr_mac;
                y_rd_addr = y_addr_mac;
            end
            ST_WRITE: begin
                z_wr_en = 1'b1;
                z_din   = acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            pipe_valid  <= 1'b0;
            done        <= 1'b0;
            x_addr_hold <= '0;
            y_addr_hold <= '0;
        end else begin
            x_addr_hold <= x_rd_addr;
            y_addr_hold <= y_rd_addr;
            pipe_valid  <= (state == ST_MAC);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        i    <= '0;
                        j    <= '0;
                        k    <= '0;
                        done <= 1'b0;
                    end else begin
                        done <= (state == ST_DONE);
                    end
                end
                ST_MAC: k <= k + 1'b1;
                ST_WRITE: begin
                    k <= '0;
                    if (j != LAST) begin
                        j <= j + 1'b1;
                    end else begin
                        j <= '0;
                        if (i != LAST) i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    matmul_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clear (acc_clear),
        .valid (pipe_valid),
        .a     (x_dout),
        .b     (y_dout),
        .acc   (acc)
    );

endmodule

`default_nettype wire

// File: tb/tb_matmul_engine.sv
// ============================================================================
// tb_matmul_engine : self-checking bench with BRAM models and a matrix model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matmul_engine;

    localparam int N       = 8;
    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int NN      = N * N;
    localparam int EXP_LAT = N * N * (N + 2) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] x_rd_addr;
    logic [AW-1:0] y_rd_addr;
    logic [AW-1:0] z_wr_addr;
    logic [DW-1:0] x_dout = '0;
    logic [DW-1:0] y_dout = '0;
    logic          z_wr_en;
    logic [DW-1:0] z_din;

    logic [DW-1:0] x_mem [NN];
    logic [DW-1:0] y_mem [NN];
    logic [DW-1:0] z_mem [NN];
    logic [DW-1:0] z_ref [NN];

    int vectors     = 0;
    int miscompares = 0;
    int wr_expect   = 0;
    int wr_count    = 0;

    typedef struct {
        logic [DW-1:0] xv;
        logic [DW-1:0] yv;
        logic [DW-1:0] zexp;
    } vec_t;

    vec_t tbl [4];

    matmul_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N          (N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .x_rd_addr (x_rd_addr),
        .x_dout    (x_dout),
        .y_rd_addr (y_rd_addr),
        .y_dout    (y_dout),
        .z_wr_addr (z_wr_addr),
        .z_wr_en   (z_wr_en),
        .z_din     (z_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        x_dout <= x_mem[x_rd_addr[5:0]];
        y_dout <= y_mem[y_rd_addr[5:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && z_wr_en) begin
            check("z_write_order", 64'(z_wr_addr), 64'(wr_expect));
            z_mem[z_wr_addr[5:0]] = z_din;
            wr_expect++;
            wr_count++;
        end
    end

    // Plain matrix product modulo 2^DW.
    function automatic void model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [DW-1:0] sum;
                sum = '0;
                for (int m = 0; m < N; m++) sum = sum + x_mem[r*N+m] * y_mem[m*N+c];
                z_ref[r*N+c] = sum;
            end
        end
    endfunction

    task automatic run(input int extra_at, output int lat);
        wr_expect = 0;
        wr_count  = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("done_clear_on_start", 64'(done), 64'(0));
        lat = 0;
        while (lat < 2000) begin
            @(posedge clock);
            lat++;
            #1;
            start = (lat == extra_at);
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic full_run(input string tag, input int extra_at);
        int lat;
        model();
        for (int a = 0; a < NN; a++) z_mem[a] = 32'hDEAD_BEEF;
        run(extra_at, lat);
        check({tag, "_latency"}, 64'(lat), 64'(EXP_LAT));
        check({tag, "_write_count"}, 64'(wr_count), 64'(NN));
        for (int a = 0; a < NN; a++) check({tag, "_z"}, 64'(z_mem[a]), 64'(z_ref[a]));
    endtask

    initial begin
        int cnt;

        tbl[0] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0008};
        tbl[1] = '{32'h0000_0002, 32'h0000_0003, 32'h0000_0030};
        tbl[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFF8};

        for (int a = 0; a < NN; a++) begin
            x_mem[a] = '0;
            y_mem[a] = '0;
            z_mem[a] = '0;
        end

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 64'(done), 64'(0));
        check("rst_z_wr_en", 64'(z_wr_en), 64'(0));
        check("rst_x_addr", 64'(x_rd_addr), 64'(0));
        check("rst_y_addr", 64'(y_rd_addr), 64'(0));
        check("rst_z_addr", 64'(z_wr_addr), 64'(0));
        check("rst_z_din", 64'(z_din), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // Identity times ramp returns the ramp.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                x_mem[r*N+c] = (r == c) ? 32'd1 : 32'd0;
                y_mem[r*N+c] = 32'(r*N+c);
            end
        full_run("identity", -1);
        for (int a = 0; a < NN; a++) check("identity_ramp", 64'(z_mem[a]), 64'(a));

        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < NN; a++) begin
                x_mem[a] = tbl[t].xv;
                y_mem[a] = tbl[t].yv;
            end
            full_run("table", -1);
            for (int a = 0; a < NN; a++) check("table_const", 64'(z_mem[a]), 64'(tbl[t].zexp));
        end

        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < NN; a++) begin
                x_mem[a] = (t == 2) ? 32'($urandom_range(0, 15)) : $urandom;
                y_mem[a] = (t == 2) ? 32'($urandom_range(0, 15)) : $urandom;
            end
            full_run("random", -1);
        end

        // Stray start mid-run, then restart from DONE with identical data.
        full_run("extra_start", 100);
        repeat (3) @(negedge clock);
        check("done_held", 64'(done), 64'(1));
        full_run("restart_done", -1);

        // Asynchronous reset in the middle of a run.
        for (int a = 0; a < NN; a++) begin
            x_mem[a] = $urandom;
            y_mem[a] = $urandom;
        end
        wr_expect = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clock);
            cnt++;
        end
        #1;
        reset = 1'b0;
        #1;
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_z_wr_en", 64'(z_wr_en), 64'(0));
        check("midrst_x_addr", 64'(x_rd_addr), 64'(0));
        check("midrst_y_addr", 64'(y_rd_addr), 64'(0));
        check("midrst_z_addr", 64'(z_wr_addr), 64'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("post_rst_no_write", 64'(z_wr_en), 64'(0));
            check("post_rst_no_done", 64'(done), 64'(0));
        end
        full_run("after_reset", -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
Compute engine behind the matrix-multiply top. After start, it reads square matrices X and Y (N×N, row-major) from two synchronous-read BRAMs, computes Z = X·Y, and writes Z row-major into the Z BRAM. It is the reader of the x/y buffers and the writer of the z buffer. The host loads X and Y through the buffers' write ports, pulses start, waits for done, then reads Z back.

Parameters:
DATA_WIDTH, 32, element width of X, Y, Z (two's complement; results wrap modulo 2^DATA_WIDTH)
ADDR_WIDTH, 10, BRAM address width; must satisfy 2^ADDR_WIDTH >= N*N
N, 8, matrix dimension; power of two, 2..32

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle pulse; sampled only in IDLE or DONE
done  out  1  high when Z is complete; held until next accepted start or reset
x_rd_addr  out  ADDR_WIDTH  X buffer read address
x_dout  in  DATA_WIDTH  X buffer read data, valid 1 cycle after address
y_rd_addr  out  ADDR_WIDTH  Y buffer read address
y_dout  in  DATA_WIDTH  Y buffer read data, valid 1 cycle after address
z_wr_addr  out  ADDR_WIDTH  Z buffer write address
z_wr_en  out  1  Z buffer write enable, one cycle per element
z_din  out  DATA_WIDTH  Z buffer write data

Behaviour:
- Reset (reset=0, async):
  - Outputs: done=0, z_wr_en=0, all addresses 0, z_din=0.
  - Internal: state=IDLE; counters i,j,k and accumulator cleared; read-valid pipe flag cleared.
  - Applies mid-operation too; no partial Z write follows release.
- States: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE/DONE + start=1 → MAC: i=j=k=0, acc=0, done cleared on the same edge.
- start while in MAC/DRAIN/WRITE: ignored.
- MAC, one cycle per k:
  - x_rd_addr = i*N+k, y_rd_addr = k*N+j (shift/concat, no multiplier).
  - Pipe flag set; next cycle acc += x_dout*y_dout, product truncated to DATA_WIDTH.
  - k==N-1 → DRAIN.
- DRAIN: accumulate last product (k=N-1); → WRITE.
- WRITE: z_wr_en=1, z_wr_addr=i*N+j, z_din=acc for exactly one cycle; acc cleared, k=0.
  - j<N-1 → j++, MAC.
  - Else j=0: i<N-1 → i++, MAC; i==N-1 → DONE.
- DONE: done=1 held; z_wr_en=0.
- Timing:
  - N+2 cycles per element.
  - done rises N*N*(N+2)+1 rising edges after the edge that samples start. N=8 gives 641.
- Arithmetic: element-wise and wrap modulo 2^DATA_WIDTH. Signed and unsigned give identical low bits; no saturation.
- Outside MAC, read addresses hold their last value. Z is written only in WRITE; no write on the cycle leaving reset.
- Z addresses are written in strictly increasing order 0..N*N-1, each exactly once per run.

Decomposition:
- Package matmul_pkg holds:
  - state enum (IDLE, MAC, DRAIN, WRITE, DONE);
  - localparam LOG2N = $clog2(N);
  - helper function row-major address calculation.
- Sub-module matmul_mac: registered multiply-accumulate.
  - Inputs: clear, valid, a, b.
  - Output: acc.
  - Same async active-low reset.

Test Plan:
- X=identity, Y[r][c]=r*8+c (N=8), start → z_dout at every addr a equals a; 64 z_wr_en pulses; 0 errors.
- X all 1, Y all 1 → every Z element = 0x00000008; done rises exactly 641 cycles after start sampled.
- X all 0x00000002, Y all 0x00000003 → every Z element = 0x00000030.
- Overflow: X all 0x00010000, Y all 0x00010000 → each product truncates to 0, Z all 0x00000000. X all 0xFFFFFFFF, Y all 1 → Z all 0xFFFFFFF8.
- Reset mid-run: assert reset at cycle 200 for 2 cycles → done=0, z_wr_en=0, address 0 immediately. Then restart → full correct Z and done at +641.
- Second start pulse at cycle 100 of a run → ignored; done still at 641. Start again in DONE → done drops next edge; identical Z rewritten.
